// File: rtl/cmos_pkg.sv
// cmos_pkg: shared defaults and FSM state encoding for the CMOS arbiter.
// The CLR_RUN state exists only when CMOS_CLEAR_EN is defined.
package cmos_pkg;

   localparam int unsigned CMOS_ADDR_W    = 10;
   localparam int unsigned CMOS_DATA_W    = 4;
   localparam logic [3:0]  CMOS_CLEAR_VAL = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_HPS_GRANT = 2'd1,
      ST_HPS_ACK   = 2'd2
`ifdef CMOS_CLEAR_EN
      ,
      ST_CLR_RUN   = 2'd3
`endif
   } cmos_state_t;

endpackage

// File: rtl/cmos_arbiter.sv
// cmos_arbiter: shares one external single-port CMOS RAM between the CPU
// (absolute priority, never stalled) and the HPS (request/ack handshake).
// Optional high-score clear sweep is built in with `define CMOS_CLEAR_EN.
module cmos_arbiter
   import cmos_pkg::*;
#(
   parameter int unsigned       ADDR_W    = CMOS_ADDR_W,
   parameter int unsigned       DATA_W    = CMOS_DATA_W,
   parameter logic [DATA_W-1:0] CLEAR_VAL = DATA_W'(CMOS_CLEAR_VAL)
) (
   input  logic              clock_12,
   input  logic              reset_n,
   input  logic              cpu_cs,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_din,
   output logic [DATA_W-1:0] cpu_dout,
   input  logic              hps_req,
   input  logic              hps_we,
   input  logic [ADDR_W-1:0] hps_addr,
   input  logic [7:0]        hps_din,
   output logic [DATA_W-1:0] hps_dout,
   output logic              hps_ack,
   input  logic              clear_req,
   output logic              busy,
   output logic              dirty,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   cmos_state_t       r_state;
   logic              r_hps_ack;
   logic [DATA_W-1:0] r_hps_dout;
   logic              r_hps_rd;
   logic              r_rd_last;
   logic              r_dirty;

   logic              w_cpu_wr;
   logic              w_hps_grant;
   logic              w_clr_start;
   logic              w_clr_done;
   logic              w_unused;

   assign w_cpu_wr = cpu_cs & cpu_we;
   assign w_unused = ^{clear_req, hps_din, CLEAR_VAL};

`ifdef CMOS_CLEAR_EN
   logic              r_clear_q;
   logic              r_clr_pend;
   logic              r_busy;
   logic [ADDR_W-1:0] r_clr_cnt;
   logic              w_clr_edge;
   logic              w_clr_wr;

   assign w_clr_edge  = clear_req & ~r_clear_q;
   assign w_clr_start = (r_state == ST_IDLE) & (w_clr_edge | r_clr_pend);
   assign w_clr_wr    = (r_state == ST_CLR_RUN) & ~cpu_cs;
   assign w_clr_done  = w_clr_wr & (r_clr_cnt == LAST_ADDR);
   assign busy        = r_busy;
`else
   assign w_clr_start = 1'b0;
   assign w_clr_done  = 1'b0;
   assign busy        = 1'b0;
`endif

   // The HPS access itself happens in the granting IDLE cycle, so the
   // registered RAM read data is already present during HPS_GRANT.
   assign w_hps_grant = (r_state == ST_IDLE) & hps_req & ~cpu_cs & ~w_clr_start;

   assign cpu_dout = ram_dout;
   assign hps_dout = r_hps_dout;
   assign hps_ack  = r_hps_ack;
   assign dirty    = r_dirty;

   // RAM port mux: CPU first, then a granted HPS access, then the clear sweep.
   always_comb begin
      ram_addr = cpu_addr;
      ram_we   = w_cpu_wr;
      ram_din  = cpu_din;
      if (!cpu_cs) begin
         if (w_hps_grant) begin
            ram_addr = hps_addr;
            ram_we   = hps_we;
            ram_din  = hps_din[DATA_W-1:0];
         end
`ifdef CMOS_CLEAR_EN
         else if (w_clr_wr) begin
            ram_addr = r_clr_cnt;
            ram_we   = 1'b1;
            ram_din  = CLEAR_VAL;
         end
`endif
      end
   end

   // Arbitration FSM with registered ack/read data and the inline clear sequencer.
   always_ff @(posedge clock_12 or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_hps_ack  <= 1'b0;
         r_hps_dout <= '0;
         r_hps_rd   <= 1'b0;
         r_rd_last  <= 1'b0;
`ifdef CMOS_CLEAR_EN
         r_clear_q  <= 1'b0;
         r_clr_pend <= 1'b0;
         r_busy     <= 1'b0;
         r_clr_cnt  <= '0;
`endif
      end else begin
         r_hps_ack <= 1'b0;
         case (r_state)
            ST_IDLE: begin
`ifdef CMOS_CLEAR_EN
               if (w_clr_start) begin
                  r_state    <= ST_CLR_RUN;
                  r_busy     <= 1'b1;
                  r_clr_pend <= 1'b0;
               end else
`endif
               if (w_hps_grant) begin
                  r_state   <= ST_HPS_GRANT;
                  r_hps_rd  <= ~hps_we;
                  r_rd_last <= ~hps_we & (hps_addr == LAST_ADDR);
               end
            end
            ST_HPS_GRANT: begin
               r_state   <= ST_HPS_ACK;
               r_hps_ack <= 1'b1;
               if (r_hps_rd) r_hps_dout <= ram_dout;
            end
            ST_HPS_ACK: begin
               r_state <= ST_IDLE;
            end
`ifdef CMOS_CLEAR_EN
            ST_CLR_RUN: begin
               if (w_clr_wr) begin
                  r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
                  if (w_clr_done) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
`endif
            default: r_state <= ST_IDLE;
         endcase
`ifdef CMOS_CLEAR_EN
         r_clear_q <= clear_req;
         if (w_clr_edge && (r_state == ST_HPS_GRANT || r_state == ST_HPS_ACK))
            r_clr_pend <= 1'b1;
`endif
      end
   end

   // Dirty flag: CPU writes and sweep completion set it, a full-save read of the last address clears it.
   always_ff @(posedge clock_12 or negedge reset_n) begin
      if (!reset_n) begin
         r_dirty <= 1'b0;
      end else if (w_cpu_wr || w_clr_done) begin
         r_dirty <= 1'b1;
      end else if (r_hps_ack && r_rd_last) begin
         r_dirty <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cmos_arbiter.sv
// tb_cmos_arbiter: scoreboard bench for cmos_arbiter with a behavioural
// external RAM. Clear-sweep scenarios are compiled in with CMOS_CLEAR_EN.
module tb_cmos_arbiter;

   logic       clk;
   logic       reset_n;
   logic       cpu_cs, cpu_we;
   logic [9:0] cpu_addr;
   logic [3:0] cpu_din, cpu_dout;
   logic       hps_req, hps_we;
   logic [9:0] hps_addr;
   logic [7:0] hps_din;
   logic [3:0] hps_dout;
   logic       hps_ack;
   logic       clear_req, busy, dirty;
   logic [9:0] ram_addr;
   logic       ram_we;
   logic [3:0] ram_din, ram_dout;
   logic       preload;

   typedef struct packed {
      logic       rd;
      logic [3:0] data;
   } sb_t;

   sb_t        exp_q[$];
   logic [3:0] exp_mem [1024];
   logic [3:0] mem [1024];
   int         n_checks = 0;
   int         n_errors = 0;

   cmos_arbiter #(
      .ADDR_W    (10),
      .DATA_W    (4),
      .CLEAR_VAL (4'hF)
   ) dut (
      .clock_12  (clk),
      .reset_n   (reset_n),
      .cpu_cs    (cpu_cs),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_din   (cpu_din),
      .cpu_dout  (cpu_dout),
      .hps_req   (hps_req),
      .hps_we    (hps_we),
      .hps_addr  (hps_addr),
      .hps_din   (hps_din),
      .hps_dout  (hps_dout),
      .hps_ack   (hps_ack),
      .clear_req (clear_req),
      .busy      (busy),
      .dirty     (dirty),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] pat(input int a);
      return 4'(a % 15);
   endfunction

   // External single-port RAM, registered read, with a bench-only bulk preload.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
      end else if (ram_we) begin
         mem[ram_addr] <= ram_din;
      end
      ram_dout <= mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Every ack retires exactly one queued request; reads are compared here.
   always @(negedge clk) begin
      if (hps_ack) begin
         if (exp_q.size() == 0) begin
            chk("spurious_ack", 1, 0);
         end else begin
            sb_t e;
            e = exp_q.pop_front();
            if (e.rd) chk("hps_dout", hps_dout, e.data);
         end
      end
   end

   task automatic hps_start(input logic we, input logic [9:0] addr, input logic [7:0] din);
      sb_t e;
      e.rd   = ~we;
      e.data = exp_mem[addr];
      exp_q.push_back(e);
      if (we) exp_mem[addr] = din[3:0];
      hps_we   = we;
      hps_addr = addr;
      hps_din  = din;
      hps_req  = 1'b1;
   endtask

   task automatic hps_wait(output int lat);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!hps_ack && lat < 64);
      if (!hps_ack) chk("hps_ack_timeout", 0, 1);
      hps_req = 1'b0;
   endtask

   task automatic cpu_write(input logic [9:0] a, input logic [3:0] d);
      cpu_cs   = 1'b1;
      cpu_we   = 1'b1;
      cpu_addr = a;
      cpu_din  = d;
      exp_mem[a] = d;
      @(posedge clk); #1;
      cpu_cs = 1'b0;
      cpu_we = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   lat;
      int   cnt;
      logic found;
      logic saw_ack;
      logic bad;

      reset_n = 1'b1; preload = 1'b0;
      cpu_cs = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
      hps_req = 1'b0; hps_we = 1'b0; hps_addr = '0; hps_din = '0;
      clear_req = 1'b0;
      #2 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hps_ack", hps_ack, 0);
      chk("rst_hps_dout", hps_dout, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dirty", dirty, 0);
      chk("rst_ram_we_idle", ram_we, 0);
      cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h3FE;
      #1 chk("rst_ram_we_cpu", ram_we, 1);
      cpu_cs = 1'b0; cpu_we = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;

      preload = 1'b1;
      for (int i = 0; i < 1024; i++) exp_mem[i] = pat(i);
      @(posedge clk); #1;
      preload = 1'b0;

      // HPS write then read back, low nibble only
      hps_start(1'b1, 10'h005, 8'hA3);
      hps_wait(lat);
      chk("hps_wr_latency", lat, 2);
      hps_start(1'b0, 10'h005, 8'h00);
      hps_wait(lat);
      chk("hps_rd_latency", lat, 3);
      @(posedge clk); #1;
      chk("dirty_no_cpu_wr", dirty, 0);

      // CPU write passes straight through and sets dirty
      cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h010; cpu_din = 4'h9;
      exp_mem[10'h010] = 4'h9;
      #1;
      chk("cpu_ram_we", ram_we, 1);
      chk("cpu_ram_addr", ram_addr, 10'h010);
      chk("cpu_ram_din", ram_din, 4'h9);
      @(posedge clk); #1;
      chk("dirty_after_cpu_wr", dirty, 1);
      cpu_we = 1'b0;
      @(posedge clk); #1;
      cpu_cs = 1'b0;
      @(posedge clk); #1;
      chk("cpu_dout", cpu_dout, 4'h9);

      // HPS request held off while the CPU owns the port
      cpu_cs = 1'b1; cpu_addr = 10'h020;
      hps_start(1'b1, 10'h030, 8'h5C);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("blocked_no_ack", hps_ack, 0);
         chk("blocked_ram_addr", ram_addr, 10'h020);
         chk("blocked_ram_we", ram_we, 0);
         @(posedge clk); #1;
      end
      cpu_cs = 1'b0;
      hps_wait(lat);
      chk("blocked_ack_latency", lat, 2);
      @(posedge clk); #1;
      hps_start(1'b0, 10'h030, 8'h00);
      hps_wait(lat);

      // Full-save read of the last address clears dirty
      @(posedge clk); #1;
      hps_start(1'b0, 10'h3FF, 8'h00);
      hps_wait(lat);
      @(posedge clk); #1;
      chk("dirty_cleared", dirty, 0);

      // CPU write in the same cycle as the clearing ack: set wins
      cpu_write(10'h011, 4'h4);
      hps_start(1'b0, 10'h3FF, 8'h00);
      hps_wait(lat);
      cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h3FF; cpu_din = 4'h7;
      exp_mem[10'h3FF] = 4'h7;
      @(posedge clk); #1;
      cpu_cs = 1'b0; cpu_we = 1'b0;
      chk("dirty_set_wins", dirty, 1);
      hps_start(1'b0, 10'h3FF, 8'h00);
      hps_wait(lat);
      @(posedge clk); #1;
      chk("dirty_cleared_again", dirty, 0);

`ifdef CMOS_CLEAR_EN
      // Sweep with the CPU toggling every cycle; a pending HPS read waits it out
      clear_req = 1'b1;
      @(posedge clk); #1;
      clear_req = 1'b0;
      chk("busy_on_clear", busy, 1);
      for (int i = 0; i < 1024; i++) exp_mem[i] = 4'hF;
      hps_start(1'b0, 10'h100, 8'h00);
      cnt = 0; saw_ack = 1'b0;
      while (busy && cnt < 5000) begin
         cnt++;
         cpu_cs   = cnt[0];
         cpu_we   = (cnt == 1);
         cpu_addr = (cnt == 1) ? 10'h3F0 : 10'h020;
         cpu_din  = 4'h2;
         @(posedge clk); #1;
         if (hps_ack) saw_ack = 1'b1;
      end
      cpu_cs = 1'b0; cpu_we = 1'b0;
      chk("busy_cycles", cnt, 2048);
      chk("no_ack_while_busy", saw_ack, 0);
      chk("dirty_after_sweep", dirty, 1);
      hps_wait(lat);
      chk("ack_after_sweep_latency", lat, 2);
      for (int a = 0; a < 1024; a++) begin
         hps_start(1'b0, 10'(a), 8'h00);
         hps_wait(lat);
      end
      @(posedge clk); #1;
      chk("dirty_after_full_save", dirty, 0);

      // Clear edge during an HPS access is latched; reset aborts the sweep at 0x100
      preload = 1'b1;
      for (int i = 0; i < 1024; i++) exp_mem[i] = pat(i);
      @(posedge clk); #1;
      preload = 1'b0;
      hps_start(1'b0, 10'h050, 8'h00);
      @(posedge clk); #1;
      clear_req = 1'b1;
      @(posedge clk); #1;
      clear_req = 1'b0;
      chk("latched_clr_ack", hps_ack, 1);
      hps_req = 1'b0;
      cnt = 0;
      while (!busy && cnt < 10) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("latched_clr_start", cnt, 2);
      found = 1'b0;
      for (int j = 0; j < 2000; j++) begin
         #1;
         if (ram_we && ram_addr == 10'h100) begin
            found = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      chk("sweep_reached_100", found, 1);
      reset_n = 1'b0;
      #1;
      chk("abort_busy_async", busy, 0);
      chk("abort_dirty", dirty, 0);
      @(posedge clk); #1;
      chk("abort_busy_edge", busy, 0);
      chk("abort_ram_we", ram_we, 0);
      reset_n = 1'b1;
      for (int i = 0; i < 256; i++) exp_mem[i] = 4'hF;
      @(posedge clk); #1;
      for (int a = 10'h0F0; a < 1024; a++) begin
         hps_start(1'b0, 10'(a), 8'h00);
         hps_wait(lat);
      end
`else
      // Without the clear feature a clear request does nothing
      bad = 1'b0;
      clear_req = 1'b1;
      #1 if (busy || ram_we) bad = 1'b1;
      @(posedge clk); #1;
      clear_req = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #1 if (busy || ram_we) bad = 1'b1;
         @(posedge clk); #1;
      end
      chk("no_clear_activity", bad, 0);
      hps_start(1'b1, 10'h123, 8'h5A);
      hps_wait(lat);
      chk("noclr_hps_wr_latency", lat, 2);
      @(posedge clk); #1;
      hps_start(1'b0, 10'h123, 8'h00);
      hps_wait(lat);
      chk("noclr_hps_rd_latency", lat, 2);
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cmos_arbiter.md
CMOS_ARBITER -- requirements
Module: cmos_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, gives the CMOS address width (1024 locations).
REQ-002 Parameter DATA_W, default 4, gives the CMOS data width.
REQ-003 Parameter CLEAR_VAL, default 4'hF, is the nibble written by a clear sweep.
REQ-004 clock_12  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  asynchronous reset, active low.
REQ-006 cpu_cs  in  1  CPU selects CMOS this cycle.
REQ-007 cpu_we  in  1  CPU write strobe, qualified by cpu_cs.
REQ-008 cpu_addr  in  ADDR_W  CPU address.
REQ-009 cpu_din  in  DATA_W  CPU write data.
REQ-010 cpu_dout  out  DATA_W  CPU read data, equal to ram_dout.
REQ-011 hps_req  in  1  HPS access request, held high until hps_ack.
REQ-012 hps_we  in  1  HPS write (1) or read (0), stable while hps_req is high.
REQ-013 hps_addr  in  ADDR_W  HPS address.
REQ-014 hps_din  in  8  HPS byte; only bits [DATA_W-1:0] are stored.
REQ-015 hps_dout  out  DATA_W  HPS read data, valid while hps_ack is high.
REQ-016 hps_ack  out  1  one-cycle completion pulse.
REQ-017 clear_req  in  1  high-score-reset level from OSD.
REQ-018 busy  out  1  clear sweep in progress.
REQ-019 dirty  out  1  CPU has written since the last full HPS save.
REQ-020 ram_addr / ram_we / ram_din  out  ADDR_W/1/DATA_W  single-port RAM controls.
REQ-021 ram_dout  in  DATA_W  RAM read data, one-cycle registered latency.

Function
REQ-022 While cpu_cs=1, ram_addr/ram_we/ram_din SHALL combinationally follow cpu_addr/(cpu_cs&cpu_we)/cpu_din, and the CPU is never stalled.
REQ-023 FSM states: IDLE, HPS_GRANT, HPS_ACK, CLR_RUN.
REQ-024 IDLE->HPS_GRANT in the first cycle with hps_req=1 and cpu_cs=0; the HPS address/write is driven onto the RAM port in that cycle.
REQ-025 HPS_GRANT->HPS_ACK unconditionally; hps_ack=1 in HPS_ACK, and hps_dout registers ram_dout for reads; then ->IDLE.
REQ-026 A pending hps_req during cpu_cs=1 SHALL wait with no ack; no HPS access is ever lost or duplicated.
REQ-027 A rising edge of clear_req in IDLE SHALL enter CLR_RUN; an edge arriving during HPS_GRANT/HPS_ACK SHALL be latched and taken on return to IDLE.
REQ-028 CLR_RUN writes CLEAR_VAL to addresses 0..2^ADDR_W-1 ascending, one address per cycle with cpu_cs=0, and stalls on cycles with cpu_cs=1; it returns to IDLE after the last address, with the counter wrapping to 0.
REQ-029 busy=1 exactly in CLR_RUN; hps_req is ignored (no ack) while busy.
REQ-030 CPU writes during CLR_RUN SHALL still occur; a later sweep write to the same address overwrites them.
REQ-031 dirty is set by any cpu_cs&cpu_we and cleared on the HPS_ACK of a read at address 2^ADDR_W-1; if both occur in the same cycle, set wins.
REQ-032 A CLR_RUN completion SHALL set dirty.

Reset
REQ-033 reset_n=0 SHALL immediately force IDLE, hps_ack=0, hps_dout=0, busy=0, dirty=0, the clear counter to 0, and the latched clear edge cleared; ram_we then equals cpu_cs&cpu_we only.
REQ-034 Reset mid-sweep or mid-HPS access SHALL abandon it; the host must re-request.

Configuration
REQ-035 With macro CMOS_CLEAR_EN defined, CLR_RUN, clear_req handling and busy SHALL be present as specified.
REQ-036 Without CMOS_CLEAR_EN, clear_req SHALL be ignored, busy SHALL be tied 0, and the FSM SHALL have only IDLE, HPS_GRANT and HPS_ACK.

Structure
REQ-037 A shared package cmos_pkg SHALL hold the FSM state enum, the ADDR_W/DATA_W defaults and CLEAR_VAL.
REQ-038 The RAM is external; there SHALL be no sub-module, with the optional clear sequencer written inline under the macro.

Verification
REQ-039 cpu_cs=0; HPS write addr 0x005, data 0xA3 -> hps_ack 2 cycles after the request; a following HPS read of 0x005 returns hps_dout=0x3.
REQ-040 hps_req raised while cpu_cs=1 for 5 cycles -> no RAM HPS access and no ack during those cycles; ack 2 cycles after cpu_cs falls.
REQ-041 clear_req pulse with cpu_cs toggling 50% -> busy for exactly 2048 cycles; every address reads 0xF afterwards; dirty=1.
REQ-042 CPU write 0x7 to 0x3FF at the same cycle as an HPS-read ack of 0x3FF -> dirty stays 1.
REQ-043 reset_n low at sweep address 0x100 -> busy=0 next edge; addresses 0x100..0x3FF hold their prior contents.
REQ-044 Build without CMOS_CLEAR_EN; pulse clear_req -> busy=0, no RAM writes, and HPS traffic is unaffected.
